warp_scheduler: RTL and testbench

- Produces the `warp_select` index consumed by the per-warp state store and selected-warp mux.
- Tracks which warps are launched and finished, and time-slices the single core pipeline between them.
- Switches warps only at instruction boundaries or on long memory stalls, using round-robin order.
- Raises `kernel_done` when every launched warp has finished.

---
 rtl/warp_scheduler_if.sv | 37 +++
 rtl/warp_scheduler.sv | 162 ++++++++++++++++
 tb/tb_warp_scheduler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/warp_scheduler_if.sv
// warp_scheduler_if
//   Bundles the scheduler's launch/retire inputs and its selection outputs.
//   master : drives start, warp_done, core_state; observes everything else
//   slave  : the scheduler itself
//   Signals:
//     start[NUM_WARPS]      per-warp launch request (level)
//     warp_done[NUM_WARPS]  per-warp done flags from the state store
//     core_state[3]         corestate of the selected warp
//     warp_select[WSEL_W]   index of the warp owning the pipeline
//     switch_pulse          strobe in the bubble cycle after a switch
//     active_mask           launched and not yet finished warps
//     kernel_done           every launched warp has finished
//     switch_count[16]      saturating switch counter
interface warp_scheduler_if #(
  parameter int NUM_WARPS = 2
);
  localparam int WSEL_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic [NUM_WARPS-1:0] start;
  logic [NUM_WARPS-1:0] warp_done;
  logic [2:0]           core_state;
  logic [WSEL_W-1:0]    warp_select;
  logic                 switch_pulse;
  logic [NUM_WARPS-1:0] active_mask;
  logic                 kernel_done;
  logic [15:0]          switch_count;

  modport master (
    output start, warp_done, core_state,
    input  warp_select, switch_pulse, active_mask, kernel_done, switch_count
  );

  modport slave (
    input  start, warp_done, core_state,
    output warp_select, switch_pulse, active_mask, kernel_done, switch_count
  );
endinterface

// File: rtl/warp_scheduler.sv
// warp_scheduler
//   Time-slices one core pipeline between NUM_WARPS warps. Switches happen at
//   instruction boundaries (quantum expiry), on long memory stalls, or when
//   the selected warp finishes, always in round-robin order.
//   Ports:
//     clk      core clock
//     reset_n  asynchronous active-low reset
//     bus      warp_scheduler_if slave modport (see interface header)
module warp_scheduler #(
  parameter int NUM_WARPS    = 2,
  parameter int QUANTUM      = 4,
  parameter int STALL_THRESH = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  warp_scheduler_if.slave   bus
);
  localparam int WSEL_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  localparam logic [2:0] CORE_WAIT   = 3'b100;
  localparam logic [2:0] CORE_UPDATE = 3'b110;
  localparam logic [2:0] CORE_DONE   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SWITCH, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [WSEL_W-1:0]    sel_reg, sel_next;
  logic [7:0]           q_reg, q_next;
  logic [7:0]           s_reg, s_next;
  logic [15:0]          count_reg;
  logic [NUM_WARPS-1:0] active_reg, active_next;
  logic                 bump;

  logic [NUM_WARPS-1:0] eligible;
  logic [WSEL_W-1:0]    cand_idx [NUM_WARPS];
  logic [NUM_WARPS-1:0] cand_ok;
  logic [WSEL_W-1:0]    next_idx;
  logic                 next_found;
  logic [WSEL_W-1:0]    lowest_idx;
  logic                 is_update, is_wait;
  logic [8:0]           q_inc, s_inc;

  // Done has priority over a simultaneous launch request.
  assign active_next = (active_reg | bus.start) & ~bus.warp_done;
  assign eligible    = active_reg & ~bus.warp_done;

  // cand_idx[k] is the warp k steps after the current one; k=0 is the
  // current warp itself and is never a switch candidate.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_cand
      assign cand_idx[gi] = WSEL_W'((int'(sel_reg) + gi) % NUM_WARPS);
      if (gi == 0) begin : g_self
        assign cand_ok[gi] = 1'b0;
      end else begin : g_other
        assign cand_ok[gi] = eligible[cand_idx[gi]];
      end
    end
  endgenerate

  // Descending scans so the nearest candidate / lowest index wins.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      if (cand_ok[k]) begin
        next_found = 1'b1;
        next_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (eligible[i]) lowest_idx = WSEL_W'(i);
    end
  end

  assign is_update = (bus.core_state == CORE_UPDATE);
  assign is_wait   = (bus.core_state == CORE_WAIT);
  assign q_inc     = {1'b0, q_reg} + {8'd0, is_update};
  assign s_inc     = is_wait ? ({1'b0, s_reg} + 9'd1) : 9'd0;

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    q_next     = q_reg;
    s_next     = s_reg;
    bump       = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        q_next = '0;
        s_next = '0;
        if (|eligible) begin
          sel_next   = lowest_idx;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        q_next = q_inc[7:0];
        s_next = s_inc[7:0];
        if (bus.warp_done[sel_reg] || bus.core_state == CORE_DONE) begin
          q_next = '0;
          s_next = '0;
          if (next_found) begin
            sel_next   = next_idx;
            state_next = S_SWITCH;
            bump       = 1'b1;
          end else begin
            state_next = S_DONE;
          end
        end else if ((is_wait && s_inc >= 9'(STALL_THRESH)) ||
                     (is_update && q_inc >= 9'(QUANTUM))) begin
          // With nobody to switch to, the warp keeps running on fresh counters.
          q_next = '0;
          s_next = '0;
          if (next_found) begin
            sel_next   = next_idx;
            state_next = S_SWITCH;
            bump       = 1'b1;
          end
        end
      end
      S_SWITCH: begin
        q_next     = '0;
        s_next     = '0;
        state_next = S_RUN;
      end
      S_DONE: begin
        if (|eligible) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // warp_select and the switch count update at the decision edge, so both
  // are already valid during the S_SWITCH bubble cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      sel_reg    <= '0;
      q_reg      <= '0;
      s_reg      <= '0;
      count_reg  <= '0;
      active_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      q_reg      <= q_next;
      s_reg      <= s_next;
      active_reg <= active_next;
      if (bump && count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
    end
  end

  assign bus.warp_select  = sel_reg;
  assign bus.switch_pulse = (state_reg == S_SWITCH);
  assign bus.kernel_done  = (state_reg == S_DONE);
  assign bus.active_mask  = active_reg;
  assign bus.switch_count = count_reg;
endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: a 2-warp instance for launch, stall,
// retire, reset and saturation cases, a 4-warp instance for round-robin wrap.
module tb_warp_scheduler;
  localparam logic [2:0] C_FETCH  = 3'b001;
  localparam logic [2:0] C_DEC    = 3'b010;
  localparam logic [2:0] C_EXEC   = 3'b011;
  localparam logic [2:0] C_WAIT   = 3'b100;
  localparam logic [2:0] C_UPDATE = 3'b110;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  warp_scheduler_if #(.NUM_WARPS(2)) b2 ();
  warp_scheduler_if #(.NUM_WARPS(4)) b4 ();

  warp_scheduler #(.NUM_WARPS(2), .QUANTUM(4), .STALL_THRESH(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave)
  );
  warp_scheduler #(.NUM_WARPS(4), .QUANTUM(4), .STALL_THRESH(3)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(b4.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic [2:0] v);
    b2.core_state = v;
    b4.core_state = v;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    b2.start = '0; b2.warp_done = '0;
    b4.start = '0; b4.warp_done = '0;
    set_core(C_FETCH);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // One four-cycle instruction ending on its UPDATE edge.
  task automatic instr();
    set_core(C_FETCH);  tick();
    set_core(C_DEC);    tick();
    set_core(C_EXEC);   tick();
    set_core(C_UPDATE); tick();
  endtask

  task automatic wait_pulse2(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (b2.switch_pulse) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pulse_seen;

    // Reset state
    do_reset();
    check("rst_sel",   b2.warp_select, 0);
    check("rst_pulse", b2.switch_pulse, 0);
    check("rst_mask",  b2.active_mask, 0);
    check("rst_kdone", b2.kernel_done, 0);
    check("rst_count", b2.switch_count, 0);

    // Launch and quantum expiry
    b2.start = 2'b11;
    tick();
    check("launch_mask", b2.active_mask, 2'b11);
    tick();
    check("launch_sel", b2.warp_select, 0);
    check("launch_nopulse", b2.switch_pulse, 0);
    instr(); instr(); instr();
    check("q3_nopulse", b2.switch_pulse, 0);
    check("q3_sel", b2.warp_select, 0);
    instr();
    check("q4_pulse", b2.switch_pulse, 1);
    check("q4_sel", b2.warp_select, 1);
    check("q4_count", b2.switch_count, 1);
    set_core(C_FETCH); tick();
    check("q4_pulse_off", b2.switch_pulse, 0);
    check("q4_sel_hold", b2.warp_select, 1);

    // Stall switch with warp 1 eligible
    do_reset();
    b2.start = 2'b11;
    tick(); tick();
    set_core(C_WAIT);
    tick(); tick();
    check("stall2_nopulse", b2.switch_pulse, 0);
    tick();
    check("stall3_pulse", b2.switch_pulse, 1);
    check("stall3_sel", b2.warp_select, 1);

    // Stall with no other warp launched
    do_reset();
    b2.start = 2'b01;
    tick(); tick();
    set_core(C_WAIT);
    pulse_seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (b2.switch_pulse) pulse_seen = 1'b1;
    end
    check("lone_stall_pulse", {31'd0, pulse_seen}, 0);
    check("lone_stall_sel", b2.warp_select, 0);
    check("lone_stall_count", b2.switch_count, 0);

    // Done sequence and relaunch
    do_reset();
    b2.start = 2'b11;
    tick(); tick();
    b2.start = 2'b10; b2.warp_done = 2'b01;
    tick();
    check("done0_pulse", b2.switch_pulse, 1);
    check("done0_sel", b2.warp_select, 1);
    check("done0_mask", b2.active_mask, 2'b10);
    tick();
    b2.start = 2'b00; b2.warp_done = 2'b11;
    tick();
    check("done1_kdone", b2.kernel_done, 1);
    check("done1_mask", b2.active_mask, 0);
    check("done1_count", b2.switch_count, 1);
    tick();
    check("done_sel_hold", b2.warp_select, 1);
    b2.start = 2'b01; b2.warp_done = 2'b00;
    tick();
    check("relaunch_kdone_still", b2.kernel_done, 1);
    tick();
    check("relaunch_kdone_clear", b2.kernel_done, 0);
    tick();
    check("relaunch_sel", b2.warp_select, 0);

    // Simultaneous start and done
    do_reset();
    b2.start = 2'b10; b2.warp_done = 2'b10;
    tick();
    check("simul_mask", b2.active_mask, 0);
    b2.warp_done = 2'b00;
    tick();
    check("simul_then_start", b2.active_mask, 2'b10);

    // Asynchronous reset during S_SWITCH
    do_reset();
    b2.start = 2'b11;
    tick(); tick();
    instr(); instr(); instr(); instr();
    check("pre_rst_pulse", b2.switch_pulse, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_pulse", b2.switch_pulse, 0);
    check("arst_sel", b2.warp_select, 0);
    check("arst_count", b2.switch_count, 0);
    check("arst_mask", b2.active_mask, 0);
    b2.start = 2'b00;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    check("arst_after_pulse", b2.switch_pulse, 0);
    check("arst_after_count", b2.switch_count, 0);

    // Saturation: preload the counter near the top, then switch via stalls
    do_reset();
    b2.start = 2'b11;
    tick(); tick();
    #2;
    force dut2.count_reg = 16'hFFFD;
    #1;
    release dut2.count_reg;
    set_core(C_WAIT);
    wait_pulse2("sat_sw1");
    check("sat_cnt1", b2.switch_count, 16'hFFFE);
    wait_pulse2("sat_sw2");
    check("sat_cnt2", b2.switch_count, 16'hFFFF);
    wait_pulse2("sat_sw3");
    check("sat_cnt3", b2.switch_count, 16'hFFFF);

    // Round-robin wrap with 4 warps, only 1 and 3 launched
    do_reset();
    b4.start = 4'b1010;
    tick();
    check("rr_mask", b4.active_mask, 4'b1010);
    tick();
    check("rr_first_sel", b4.warp_select, 1);
    instr(); instr(); instr(); instr();
    check("rr_to3", b4.warp_select, 3);
    instr(); instr(); instr(); instr();
    check("rr_wrap_to1", b4.warp_select, 1);
    check("rr_wrap_pulse", b4.switch_pulse, 1);
    check("rr_count", b4.switch_count, 2);
    instr(); instr(); instr(); instr();
    check("rr_back_to3", b4.warp_select, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
